// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image_stream_proc slice:
//   - point-operation mode codes (MODE_PASS/MODE_BRIGHT/MODE_INVERT/MODE_THRESH)
//   - frame FSM state encoding (ST_BLANK exists only when HBLANK_EN is defined)
//   - default colour component width
//   - max_val(): largest value of an unsigned component of a given width
// Optional build macro: HBLANK_EN (adds the horizontal blanking state).
// ---------------------------------------------------------------------------
package img_pkg;

  localparam int DEFAULT_DW = 8;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BRIGHT = 2'd1;
  localparam logic [1:0] MODE_INVERT = 2'd2;
  localparam logic [1:0] MODE_THRESH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1
`ifdef HBLANK_EN
    ,
    ST_BLANK = 2'd2
`endif
  } state_t;

  function automatic int max_val(input int dw);
    return (1 << dw) - 1;
  endfunction

endpackage

// File: rtl/image_stream_proc_if.sv
// ---------------------------------------------------------------------------
// image_stream_proc_if
// Pixel stream bundle around image_stream_proc.
//   in_valid/in_ready/in_data       : upstream beats, NPIX packed {R,G,B} pixels
//   out_valid/out_ready/out_data    : processed beats, same packing
//   out_hsync/out_eol/out_eof       : line/frame markers riding with out beats
// Modports:
//   slave  - the processing block (accepts input, drives output)
//   master - the environment (frame source + BMP writer side)
// ---------------------------------------------------------------------------
interface image_stream_proc_if #(
  parameter int NPIX = 2,
  parameter int DW   = img_pkg::DEFAULT_DW
);
  localparam int BW = NPIX * 3 * DW;

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_hsync;
  logic          out_eol;
  logic          out_eof;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_hsync, out_eol, out_eof
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_hsync, out_eol, out_eof
  );

endinterface

// File: rtl/img_pix_op.sv
// ---------------------------------------------------------------------------
// img_pix_op
// Two-stage point-operation datapath for a single {R,G,B} pixel.
//   Stage 1: component copy, R+G+B sum, per-component brightness result with
//            one extra bit (carry for add, borrow for subtract).
//   Stage 2: final components selected by mode.
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   en                    both stages advance when high
//   mode/sign/value/thresh frame-constant operation controls
//   pix_in / pix_out      packed {R,G,B}, R in the MSBs
// ---------------------------------------------------------------------------
module img_pix_op
  import img_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic            sign,
  input  logic [DW-1:0]   value,
  input  logic [DW-1:0]   thresh,
  input  logic [3*DW-1:0] pix_in,
  output logic [3*DW-1:0] pix_out
);

  localparam logic [DW-1:0] MAXC = DW'(max_val(DW));

  logic [DW-1:0] c_in  [3];
  logic [DW:0]   br_in [3];
  logic [DW+1:0] sum_in;

  logic [DW-1:0] s1_c  [3];
  logic [DW:0]   s1_br [3];
  logic [DW+1:0] s1_sum;

  logic [DW+1:0] gray;
  logic [DW-1:0] res [3];

  // Split the pixel into components (index 0 = R) and form the stage-1
  // values. The brightness result keeps one extra MSB: for add it is the
  // carry out, for subtract it is the borrow (result went negative).
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      c_in[k]  = pix_in[(2-k)*DW +: DW];
      br_in[k] = sign ? ({1'b0, c_in[k]} + {1'b0, value})
                      : ({1'b0, c_in[k]} - {1'b0, value});
    end
    sum_in = {2'b00, c_in[0]} + {2'b00, c_in[1]} + {2'b00, c_in[2]};
  end

  // Stage 1 register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_sum <= '0;
      for (int k = 0; k < 3; k++) begin
        s1_c[k]  <= '0;
        s1_br[k] <= '0;
      end
    end else if (en) begin
      s1_sum <= sum_in;
      for (int k = 0; k < 3; k++) begin
        s1_c[k]  <= c_in[k];
        s1_br[k] <= br_in[k];
      end
    end
  end

  // Final component selection. Saturation uses the extra MSB from stage 1;
  // gray is the truncating average of the three components.
  always_comb begin
    gray = s1_sum / (DW+2)'(3);
    for (int k = 0; k < 3; k++) begin
      res[k] = s1_c[k];
      case (mode)
        MODE_PASS:   res[k] = s1_c[k];
        MODE_BRIGHT: begin
          if (sign) res[k] = s1_br[k][DW] ? MAXC : s1_br[k][DW-1:0];
          else      res[k] = s1_br[k][DW] ? '0   : s1_br[k][DW-1:0];
        end
        MODE_INVERT: res[k] = MAXC - gray[DW-1:0];
        MODE_THRESH: res[k] = (gray > {2'b00, thresh}) ? MAXC : '0;
        default:     res[k] = s1_c[k];
      endcase
    end
  end

  // Stage 2 register, which is also the block output.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) pix_out <= '0;
    else if (en)  pix_out <= {res[0], res[1], res[2]};
  end

endmodule

// File: rtl/image_stream_proc.sv
// ---------------------------------------------------------------------------
// image_stream_proc
// Streaming point processor between a frame source and a BMP writer.
// Accepts NPIX packed pixels per beat, applies the frame's selected point
// operation through a 2-stage pipeline and emits beats with line/frame
// markers. Mode controls are captured at frame start and held for the frame.
// Ports:
//   HCLK, HRESETn      clock, async active-low reset
//   start              one-cycle frame start request (honoured in IDLE only)
//   mode/sign/value/thresh  operation select and operands
//   stream (slave)     in_* input stream, out_* output stream + markers
//   busy               frame in progress
//   done               one-cycle pulse when the eof beat leaves
// Optional build macro: HBLANK_EN - HBLANK idle input cycles after every
// line except the last one.
// ---------------------------------------------------------------------------
module image_stream_proc
  import img_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int NPIX   = 2,
  parameter int DW     = DEFAULT_DW,
  parameter int HBLANK = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                sign,
  input  logic [DW-1:0]       value,
  input  logic [DW-1:0]       thresh,
  image_stream_proc_if.slave  stream,
  output logic                busy,
  output logic                done
);

  localparam int BEATS    = WIDTH * HEIGHT / NPIX;
  localparam int BEAT_W   = $clog2(BEATS + 1);
  localparam int COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LAST_COL = WIDTH - NPIX;
  localparam int LAST_ROW = HEIGHT - 1;
  localparam int BW       = NPIX * 3 * DW;

  if ((WIDTH % NPIX) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of NPIX");
  end
  if (HBLANK < 1) begin : g_bad_hblank
    $error("HBLANK must be at least 1");
  end

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic              sign_q;
  logic [DW-1:0]     value_q, thresh_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [BEAT_W-1:0] beats_q;
  logic              s1_valid, s1_eol, s1_eof;
  logic              s2_valid, s2_eol, s2_eof;
  logic              done_q;
  logic              stall, adv, in_xfer, line_end, last_row, eof_fire, start_ok;
  wire  [BW-1:0]     pix_out;

`ifdef HBLANK_EN
  localparam int BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  logic [BLANK_W-1:0] blank_cnt_q;
`endif

  // Handshake decode. The whole pipeline moves as one unit: it only freezes
  // when the output register holds a beat the downstream refuses.
  always_comb begin
    stall           = s2_valid && !stream.out_ready;
    adv             = !stall;
    stream.in_ready = (state_q == ST_RUN) && !stall && (beats_q < BEAT_W'(BEATS));
    in_xfer         = stream.in_valid && stream.in_ready;
    line_end        = (col_q == COL_W'(LAST_COL));
    last_row        = (row_q == ROW_W'(LAST_ROW));
    eof_fire        = s2_valid && stream.out_ready && s2_eof;
    // The done cycle is already IDLE; a start there belongs to the frame
    // that just finished and is dropped.
    start_ok        = (state_q == ST_IDLE) && start && !done_q;
  end

  // Next-state logic. The frame ends when the eof beat is accepted
  // downstream, not when the last input arrives, so busy covers the drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (eof_fire) state_d = ST_IDLE;
`ifdef HBLANK_EN
        else if (in_xfer && line_end && !last_row) state_d = ST_BLANK;
`endif
      end
`ifdef HBLANK_EN
      ST_BLANK: begin
        if (eof_fire) state_d = ST_IDLE;
        else if (blank_cnt_q == BLANK_W'(HBLANK - 1)) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and the registered completion pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= eof_fire;
    end
  end

`ifdef HBLANK_EN
  // Counts the cycles spent in BLANK; restarts every time BLANK is entered.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                 blank_cnt_q <= '0;
    else if (state_q != ST_BLANK) blank_cnt_q <= '0;
    else                          blank_cnt_q <= blank_cnt_q + BLANK_W'(1);
  end
`endif

  // Shadow copies of the operation controls, captured only on an accepted
  // start so mid-frame changes on the inputs have no effect.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_q   <= MODE_PASS;
      sign_q   <= 1'b0;
      value_q  <= '0;
      thresh_q <= '0;
    end else if (start_ok) begin
      mode_q   <= mode;
      sign_q   <= sign;
      value_q  <= value;
      thresh_q <= thresh;
    end
  end

  // Input position: column in pixels, row in lines, plus total beats taken
  // so in_ready drops once the frame has been fully received.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_q   <= '0;
      row_q   <= '0;
      beats_q <= '0;
    end else if (start_ok) begin
      col_q   <= '0;
      row_q   <= '0;
      beats_q <= '0;
    end else if (in_xfer) begin
      beats_q <= beats_q + BEAT_W'(1);
      if (line_end) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(NPIX);
      end
    end
  end

  // Valid and marker pipeline, kept in lockstep with the pixel datapath.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      s2_valid <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_xfer;
      s1_eol   <= in_xfer && line_end;
      s1_eof   <= in_xfer && line_end && last_row;
      s2_valid <= s1_valid;
      s2_eol   <= s1_eol;
      s2_eof   <= s1_eof;
    end
  end

  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    img_pix_op #(.DW(DW)) u_pix_op (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .en      (adv),
      .mode    (mode_q),
      .sign    (sign_q),
      .value   (value_q),
      .thresh  (thresh_q),
      .pix_in  (stream.in_data[k*3*DW +: 3*DW]),
      .pix_out (pix_out[k*3*DW +: 3*DW])
    );
  end

  assign stream.out_valid = s2_valid;
  assign stream.out_hsync = s2_valid;
  assign stream.out_eol   = s2_eol;
  assign stream.out_eof   = s2_eof;
  assign stream.out_data  = pix_out;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;

endmodule
